// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types, widths and defaults for the memory-stage SRAM controller.
package mem_stage_sram_ctrl_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned SRAM_ADDR_W = 18;
    localparam int unsigned SRAM_DATA_W = 16;
    localparam int unsigned WADDR_W     = SRAM_ADDR_W - 1;

    localparam logic [WORD_W-1:0] BASE_ADDR_DEF   = 32'd1024;
    localparam int unsigned       WAIT_CYCLES_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_DONE
    } state_e;

    // Word index of a byte address inside data memory; the subtraction wraps below base.
    function automatic logic [WADDR_W-1:0] word_addr_of(
        input logic [WORD_W-1:0] byte_addr,
        input logic [WORD_W-1:0] base
    );
        return WADDR_W'((byte_addr - base) >> 2);
    endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// Per-phase wait counter: loaded at the start of each 16-bit access, counts down to
// the final cycle of the phase and flags the cycles in which the write strobe is low.
module sram_wait_counter
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic last,
    output logic we_window
);

    localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign last      = (count == '0);
    assign we_window = !last;

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage responder: splits a 32-bit load/store into two 16-bit asynchronous SRAM
// accesses and freezes the pipeline meanwhile. Define SRAM_LAST_WRITE_HIT_EN for last-write read bypass.
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int unsigned       WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [WORD_W-1:0]      alu_res,
    input  logic [WORD_W-1:0]      st_val,
    output logic [WORD_W-1:0]      rd_data,
    output logic                   ready,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_o,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_i,
    output logic                   sram_we_n
);

    state_e              state, state_next;
    logic [WADDR_W-1:0]  req_word, word_q;
    logic [WORD_W-1:0]   data_q;
    logic                write_q;
    logic                req, read_hit, cnt_load, cnt_last, we_window;

    assign req      = mem_r_en | mem_w_en;
    assign req_word = word_addr_of(alu_res, BASE_ADDR);
    // DONE drops freeze so the pipeline advances past a request that is still visible.
    assign freeze   = req & (state != ST_DONE);

`ifdef SRAM_LAST_WRITE_HIT_EN
    logic               buf_valid;
    logic [WADDR_W-1:0] buf_addr;
    logic [WORD_W-1:0]  buf_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
        end else if (state == ST_HI && cnt_last && write_q) begin
            buf_valid <= 1'b1;
        end
    end

    // NOTE: only the valid bit is reset; address and data are qualified by it.
    always_ff @(posedge clk) begin
        if (state == ST_HI && cnt_last && write_q) begin
            buf_addr <= word_q;
            buf_data <= data_q;
        end
    end

    assign read_hit = !mem_w_en && buf_valid && (buf_addr == req_word);
`else
    assign read_hit = 1'b0;
`endif

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cnt_load),
        .last      (cnt_last),
        .we_window (we_window)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (read_hit) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_LO;
                        cnt_load   = 1'b1;
                    end
                end
            end
            ST_LO: begin
                if (cnt_last) begin
                    state_next = ST_HI;
                    cnt_load   = 1'b1;
                end
            end
            ST_HI: begin
                if (cnt_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            rd_data <= '0;
        end else begin
            if (state == ST_IDLE && req) begin
                word_q  <= req_word;
                data_q  <= st_val;
                write_q <= mem_w_en;
            end
            // The SRAM read data has settled by the final cycle of each phase.
            if (cnt_last && !write_q) begin
                if (state == ST_LO) rd_data[15:0]  <= sram_dq_i;
                if (state == ST_HI) rd_data[31:16] <= sram_dq_i;
            end
`ifdef SRAM_LAST_WRITE_HIT_EN
            if (state == ST_IDLE && req && read_hit) begin
                rd_data <= buf_data;
            end
`endif
        end
    end

    always_comb begin
        ready      = 1'b0;
        sram_addr  = '0;
        sram_dq_o  = '0;
        sram_dq_oe = 1'b0;
        sram_we_n  = 1'b1;
        case (state)
            ST_LO, ST_HI: begin
                sram_addr  = {word_q, (state == ST_HI)};
                sram_dq_o  = (state == ST_HI) ? data_q[31:16] : data_q[15:0];
                sram_dq_oe = write_q;
                // Strobe rises in the last cycle while address and data stay put.
                sram_we_n  = !(write_q && we_window);
            end
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench: directed scenarios plus randomized loads/stores against a
// word-level memory model and a behavioural asynchronous SRAM.
module tb_mem_stage_sram_ctrl;

    localparam logic [31:0] BASE = 32'd1024;
    localparam int          W    = 3;
`ifdef SRAM_LAST_WRITE_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_r_en, mem_w_en;
    logic [31:0] alu_res, st_val, rd_data;
    logic        ready, freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_we_n;

    mem_stage_sram_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .alu_res    (alu_res),
        .st_val     (st_val),
        .rd_data    (rd_data),
        .ready      (ready),
        .freeze     (freeze),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_we_n  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: reads are combinational, writes land on the rising strobe.
    logic [15:0] sram_mem [0:(1<<18)-1];
    logic        prev_we_n = 1'b1;
    assign sram_dq_i = sram_mem[sram_addr];

    always @(negedge clk) begin
        if (prev_we_n == 1'b0 && sram_we_n == 1'b1 && sram_dq_oe)
            sram_mem[sram_addr] <= sram_dq_o;
        prev_we_n <= sram_we_n;
    end

    // Reference: one 32-bit word per word address, last-write buffer, expected rd_data.
    logic [31:0] model_mem [0:(1<<17)-1];
    logic        buf_valid_m;
    logic [16:0] buf_addr_m;
    logic [31:0] buf_data_m;
    logic [31:0] exp_rd;

    int n_vec = 0;
    int n_bad = 0;
    int last_ready, last_frz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One load/store from request cycle 0 through the ready cycle; enables drop at drop_at.
    task automatic run_op(input logic r, input logic w, input logic [31:0] addr,
                          input logic [31:0] data, input int drop_at);
        logic [16:0] wa;
        bit          hit;
        int          lat, ph, pos, obs_ready, n_frz;
        wa  = 17'((addr - BASE) >> 2);
        hit = HIT_EN && !w && buf_valid_m && (buf_addr_m == wa);
        lat = hit ? 1 : 1 + 2 * W;
        if (!w) exp_rd = hit ? buf_data_m : model_mem[wa];
        obs_ready = -1;
        n_frz     = 0;
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                mem_r_en = r; mem_w_en = w; alu_res = addr; st_val = data;
            end
            if (k == drop_at) begin
                mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = $urandom; st_val = $urandom;
            end
            @(negedge clk);
            if (freeze) n_frz++;
            if (ready && obs_ready < 0) obs_ready = k;
            check("freeze", 32'(freeze), 32'(k < drop_at && k < lat));
            check("ready", 32'(ready), 32'(k == lat));
            if (k >= 1 && k < lat) begin
                ph  = (k - 1) / W;
                pos = (k - 1) % W;
                check("sram_addr", 32'(sram_addr), 32'({wa, ph[0]}));
                if (w) begin
                    check("dq_o", 32'(sram_dq_o), 32'(ph[0] ? data[31:16] : data[15:0]));
                    check("dq_oe_wr", 32'(sram_dq_oe), 32'd1);
                    check("we_n_wr", 32'(sram_we_n), 32'(pos == W - 1));
                end else begin
                    check("dq_oe_rd", 32'(sram_dq_oe), 32'd0);
                    check("we_n_rd", 32'(sram_we_n), 32'd1);
                end
            end else begin
                check("dq_oe_idle", 32'(sram_dq_oe), 32'd0);
                check("we_n_idle", 32'(sram_we_n), 32'd1);
            end
            if (k == lat) check("rd_data", rd_data, exp_rd);
        end
        if (w) begin
            model_mem[wa] = data;
            buf_valid_m   = 1'b1;
            buf_addr_m    = wa;
            buf_data_m    = data;
        end
        last_ready = obs_ready;
        last_frz   = n_frz;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = $urandom; st_val = $urandom;
            @(negedge clk);
            check("idle_freeze", 32'(freeze), 32'd0);
            check("idle_ready", 32'(ready), 32'd0);
            check("idle_we_n", 32'(sram_we_n), 32'd1);
            check("idle_oe", 32'(sram_dq_oe), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, d;
        int          sel, drop;
        for (int i = 0; i < (1 << 18); i++) sram_mem[i] = 16'h0;
        for (int i = 0; i < (1 << 17); i++) model_mem[i] = 32'h0;
        buf_valid_m = 1'b0; buf_addr_m = '0; buf_data_m = '0; exp_rd = '0;
        rst_n = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = '0; st_val = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_o", 32'(sram_dq_o), 32'd0);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_freeze", 32'(freeze), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);

        // 1: store
        run_op(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 99);
        check("t1_ready_cycle", 32'(last_ready), 32'd7);
        check("t1_freeze_cycles", 32'(last_frz), 32'd7);
        idle(1);
        check("t1_sram2", 32'(sram_mem[2]), 32'h0000BEEF);
        check("t1_sram3", 32'(sram_mem[3]), 32'h0000DEAD);

        // 2: load back
        run_op(1'b1, 1'b0, 32'd1028, 32'h0, 99);
        check("t2_load", rd_data, 32'hDEADBEEF);

        // 3: both enables -> write, rd_data held
        run_op(1'b1, 1'b1, 32'd1024, 32'h12345678, 99);
        idle(1);
        check("t3_sram0", 32'(sram_mem[0]), 32'h00005678);
        check("t3_sram1", 32'(sram_mem[1]), 32'h00001234);
        check("t3_rd_hold", rd_data, 32'hDEADBEEF);

        // 4: reset during the HI phase of a store
        @(posedge clk); #1;
        mem_w_en = 1'b1; alu_res = 32'd1040; st_val = 32'hA5A50F0F;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("t4_in_hi", 32'(sram_addr), 32'd9);
        @(negedge clk);
        check("t4_we_n", 32'(sram_we_n), 32'd1);
        check("t4_oe", 32'(sram_dq_oe), 32'd0);
        check("t4_ready", 32'(ready), 32'd0);
        check("t4_rd_data", rd_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_w_en = 1'b0;
        exp_rd = '0; buf_valid_m = 1'b0;
        run_op(1'b0, 1'b1, 32'd1040, 32'hA5A50F0F, 99);
        idle(1);
        check("t4_sram8", 32'(sram_mem[8]), 32'h00000F0F);
        check("t4_sram9", 32'(sram_mem[9]), 32'h0000A5A5);

        // 5: quiet bus
        idle(20);

`ifdef SRAM_LAST_WRITE_HIT_EN
        // 6: last-write hit
        run_op(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 99);
        run_op(1'b1, 1'b0, 32'd1032, 32'h0, 99);
        check("t6_hit_ready_cycle", 32'(last_ready), 32'd1);
        check("t6_hit_freeze", 32'(last_frz), 32'd1);
        check("t6_hit_data", rd_data, 32'hCAFEF00D);
        run_op(1'b1, 1'b0, 32'd1036, 32'h0, 99);
        check("t6_miss_ready_cycle", 32'(last_ready), 32'd7);
        check("t6_miss_freeze", 32'(last_frz), 32'd7);
`endif

        // Randomized traffic, back-to-back or with gaps, with occasional early enable drop
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0)
                a = BASE - 32'(4 * $urandom_range(1, 8)) + 32'($urandom_range(0, 3));
            else
                a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
            d    = $urandom;
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 99;
            run_op(sel != 2, sel >= 2, a, d, drop);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
Memory-stage responder for the MEM_R_EN / MEM_W_EN / EXE_CMD control word emitted by decode (LDR: read; STR: write).
Turns one 32-bit load/store into two 16-bit accesses on an external asynchronous SRAM.
Holds the pipeline with freeze until the access completes.
Sits between the EXE/MEM pipeline register and the off-chip SRAM pins.

Parameters:
BASE_ADDR, 1024, data-memory base; SRAM word address = (alu_res - BASE_ADDR) mod 2^32, bits [18:2].
WAIT_CYCLES, 3, clock cycles per 16-bit SRAM access; legal range is 2 or more.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
mem_r_en  in  1  load request from the pipeline register
mem_w_en  in  1  store request from the pipeline register
alu_res  in  32  byte address computed by the ALU
st_val  in  32  store data
rd_data  out  32  load result
ready  out  1  one-cycle pulse: access complete
freeze  out  1  stall for IF/ID/EXE/MEM pipeline registers
sram_addr  out  18  SRAM half-word address
sram_dq_o  out  16  SRAM write data
sram_dq_oe  out  1  drive enable for the SRAM data bus
sram_dq_i  in  16  SRAM read data
sram_we_n  out  1  SRAM write strobe, active-low

Behaviour:
- Reset values: rd_data=0, ready=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, sram_we_n=1, state=IDLE, wait counter=0.
- freeze = (mem_r_en | mem_w_en) & (state != DONE). It is combinational, so it is high in the same cycle the request appears.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE -> LO when either enable is high. On that edge, latch the word address, store data, and op (write if mem_w_en, else read).
  - LO -> HI after WAIT_CYCLES cycles.
  - HI -> DONE after WAIT_CYCLES cycles.
  - DONE -> IDLE unconditionally. ready=1 only in DONE.
- LO phase: sram_addr = {word_addr, 1'b0}. HI phase: sram_addr = {word_addr, 1'b1}.
- Write phases:
  - sram_dq_oe=1 for the whole phase.
  - sram_dq_o = st_val[15:0] in LO, st_val[31:16] in HI.
  - sram_we_n=0 for the first WAIT_CYCLES-1 cycles of each phase and 1 in the last cycle, so address and data are stable across the rising strobe.
- Read phases:
  - sram_dq_oe=0 and sram_we_n=1.
  - sram_dq_i is captured on the last cycle of each phase, into rd_data[15:0] (LO) and rd_data[31:16] (HI).
  - rd_data holds its value until the next read completes. Writes do not alter rd_data.
- Latency: the request is frozen for 1+2*WAIT_CYCLES cycles. ready is high in cycle 2*WAIT_CYCLES+1, counted from request cycle 0. With the default, freeze lasts 7 cycles and ready appears in cycle 7.
- DONE -> IDLE exists so that a request still visible in DONE is never re-issued. A back-to-back request is accepted in the cycle after DONE.
- Both enables high: treated as a write; the read is ignored.
- Enables dropping mid-operation: the operation still completes on the latched values. ready still pulses.
- Address below BASE_ADDR wraps modulo 2^32. Bits [1:0] are ignored (word-aligned only).
- Reset mid-operation: the next cycle is IDLE with sram_we_n=1 and sram_dq_oe=0. The partial access is abandoned and rd_data is cleared.

Optional Feature:
Macro SRAM_LAST_WRITE_HIT_EN.
- Defined:
  - A one-entry buffer holds {valid, word_addr, data} of the last completed write. valid is cleared at reset.
  - A read in IDLE whose word address matches a valid entry goes IDLE -> DONE directly, with no SRAM activity.
  - rd_data is loaded from the buffer, freeze lasts 1 cycle, and ready appears in cycle 1.
  - Every completed write updates the buffer.
- Undefined: no buffer; every read takes the full SRAM sequence.

Decomposition:
- Shared package: FSM state enum; BASE_ADDR and WAIT_CYCLES defaults; widths of the SRAM address (18), SRAM data (16) and word (32).
- One sub-module, sram_wait_counter:
  - loadable down-counter, WAIT_CYCLES wide enough;
  - outputs last (final cycle of a phase) and we_window (cycles in which sram_we_n is driven low);
  - synchronous active-low reset.

Test Plan:
1. Store: mem_w_en=1, alu_res=1028, st_val=0xDEADBEEF.
   - sram_addr=2 with dq_o=0xBEEF for 3 cycles, then sram_addr=3 with dq_o=0xDEAD for 3 cycles.
   - we_n low for 2 of each 3 cycles; freeze high 7 cycles; ready in cycle 7.
2. Load: SRAM model holds 0xBEEF at address 2 and 0xDEAD at address 3; mem_r_en=1, alu_res=1028.
   - rd_data=0xDEADBEEF when ready; we_n stays 1 and oe stays 0 throughout.
3. Both enables high, alu_res=1024, st_val=0x12345678.
   - Write to SRAM addresses 0/1 with 0x5678/0x1234; rd_data unchanged.
4. rst_n=0 during the HI phase of a store.
   - Next cycle: IDLE, we_n=1, oe=0, ready=0, rd_data=0.
   - Reasserted request restarts from the LO phase.
5. 20 cycles with no enables.
   - freeze=0, ready=0, we_n=1, oe=0 throughout.
6. With SRAM_LAST_WRITE_HIT_EN: store to 1032 with 0xCAFEF00D, then load from 1032.
   - ready in cycle 1, rd_data=0xCAFEF00D, no SRAM access.
   - A following load from 1036 takes the full 7 frozen cycles.
